// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the memory stage and data RAM.
// Single outstanding request: valid/ready request, valid-only response.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req_valid;
  logic              dmem_req_ready;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_we;
  logic [3:0]        dmem_wstrb;
  logic [31:0]       dmem_wdata;
  logic              dmem_rsp_valid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req_valid,
    output dmem_addr,
    output dmem_we,
    output dmem_wstrb,
    output dmem_wdata,
    input  dmem_req_ready,
    input  dmem_rsp_valid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req_valid,
    input  dmem_addr,
    input  dmem_we,
    input  dmem_wstrb,
    input  dmem_wdata,
    output dmem_req_ready,
    output dmem_rsp_valid,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: load/store unit with registered writeback packet.
// Non-memory ops and faulting accesses retire in one cycle.
module mem_stage_lsu #(
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [31:0]          ex_alu_result,
  input  logic [31:0]          ex_store_data,
  input  logic [2:0]           ex_funct3,
  input  logic                 ex_is_load,
  input  logic                 ex_is_store,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_rd_we,
  mem_stage_lsu_if.master      dmem,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic                 wb_we,
  output logic [31:0]          wb_data,
  output logic [1:0]           wb_exc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]    ex_addr;
  logic                 accept, is_mem;
  logic                 ld_ok, st_ok;
  logic                 ill, mis, go_mem;
  logic [1:0]           exc_now;
  logic [3:0]           st_wstrb;
  logic [31:0]          st_wdata;

  logic [ADDR_W-1:0]    q_addr;
  logic [2:0]           q_f3;
  logic [REG_IDX_W-1:0] q_rd;
  logic                 q_rd_we;
  logic                 q_store;
  logic [3:0]           q_wstrb;
  logic [31:0]          q_wdata;

  logic [31:0]          ld_word;
  logic [31:0]          ld_data;
  logic                 rsp_done;

  assign ex_addr = ex_alu_result[ADDR_W-1:0];
  assign is_mem  = ex_is_load | ex_is_store;
  assign accept  = ex_valid & ex_ready;

  always_comb begin
    ld_ok = 1'b0;
    st_ok = 1'b0;
    case (ex_funct3)
      3'b000, 3'b001, 3'b010: begin
        ld_ok = 1'b1;
        st_ok = 1'b1;
      end
      3'b100, 3'b101: ld_ok = 1'b1;
      default: ;
    endcase
  end

  assign ill = (ex_is_load & ex_is_store)
             | (ex_is_load & ~ld_ok)
             | (ex_is_store & ~st_ok);
  assign mis = ((ex_funct3[1:0] == 2'b01) & ex_addr[0])
             | ((ex_funct3[1:0] == 2'b10) & (|ex_addr[1:0]));

  assign go_mem = accept & is_mem & ~ill & ~mis;

  always_comb begin
    exc_now = 2'b00;
    unique case (1'b1)
      !is_mem: exc_now = 2'b00;
      ill:     exc_now = 2'b10;
      mis:     exc_now = 2'b01;
      default: exc_now = 2'b00;
    endcase
  end

  // Store data is replicated across lanes; the strobe picks the live bytes.
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << ex_addr[1:0];
        st_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << ex_addr[1:0];
        st_wdata = {2{ex_store_data[15:0]}};
      end
      2'b10: st_wstrb = 4'b1111;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (go_mem) state_nxt = REQ;
      REQ:  if (dmem.dmem_req_ready) state_nxt = RESP;
      RESP: if (dmem.dmem_rsp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ex_ready            = (state == IDLE) && (!wb_valid || wb_ready);
    dmem.dmem_req_valid = 1'b0;
    dmem.dmem_addr      = '0;
    dmem.dmem_we        = 1'b0;
    dmem.dmem_wstrb     = 4'b0000;
    dmem.dmem_wdata     = 32'd0;
    if (state == REQ) begin
      dmem.dmem_req_valid = 1'b1;
      dmem.dmem_addr      = {q_addr[ADDR_W-1:2], 2'b00};
      dmem.dmem_we        = q_store;
      dmem.dmem_wstrb     = q_wstrb;
      dmem.dmem_wdata     = q_wdata;
    end
  end

  assign rsp_done = (state == RESP) & dmem.dmem_rsp_valid;
  assign ld_word  = dmem.dmem_rdata >> {q_addr[1:0], 3'b000};

  always_comb begin
    ld_data = ld_word;
    case (q_f3)
      3'b000:  ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_data = {24'd0, ld_word[7:0]};
      3'b101:  ld_data = {16'd0, ld_word[15:0]};
      default: ld_data = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_addr  <= '0;
      q_f3    <= 3'd0;
      q_rd    <= '0;
      q_rd_we <= 1'b0;
      q_store <= 1'b0;
      q_wstrb <= 4'd0;
      q_wdata <= 32'd0;
    end else if (go_mem) begin
      q_addr  <= ex_addr;
      q_f3    <= ex_funct3;
      q_rd    <= ex_rd;
      q_rd_we <= ex_rd_we;
      q_store <= ex_is_store;
      q_wstrb <= ex_is_store ? st_wstrb : 4'd0;
      q_wdata <= ex_is_store ? st_wdata : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
      wb_data  <= 32'd0;
      wb_exc   <= 2'b00;
    end else if (accept && !go_mem) begin
      wb_valid <= 1'b1;
      wb_rd    <= ex_rd;
      wb_we    <= is_mem ? 1'b0 : ex_rd_we;
      wb_data  <= ex_alu_result;
      wb_exc   <= exc_now;
    end else if (rsp_done) begin
      wb_valid <= 1'b1;
      wb_rd    <= q_rd;
      wb_we    <= q_store ? 1'b0 : q_rd_we;
      wb_data  <= q_store ? 32'd0 : ld_data;
      wb_exc   <= 2'b00;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

endmodule
